// File: rtl/draw_sequencer_if.sv
// Request/grant handshake plus ROM/VGA plotting signals shared by the game-flow
// controller (master) and the draw sequencer (slave).
interface draw_sequencer_if #(
  parameter int ADDR_W = 15
) ();
  logic              screenReq;
  logic [4:0]        screenSel;
  logic              screenAck;
  logic              spriteReq;
  logic [4:0]        spriteSel;
  logic [7:0]        spriteX;
  logic [6:0]        spriteY;
  logic              spriteAck;
  logic [4:0]        memorySel;
  logic [ADDR_W-1:0] romAddr;
  logic [7:0]        x;
  logic [6:0]        y;
  logic              plot;
  logic              busy;
  logic              done;

  modport master (
    output screenReq, screenSel, spriteReq, spriteSel, spriteX, spriteY,
    input  screenAck, spriteAck, memorySel, romAddr, x, y, plot, busy, done
  );

  modport slave (
    input  screenReq, screenSel, spriteReq, spriteSel, spriteX, spriteY,
    output screenAck, spriteAck, memorySel, romAddr, x, y, plot, busy, done
  );
endinterface

// File: rtl/draw_sequencer.sv
// Arbitrates background/sprite draw jobs and walks ROM address, VGA x/y and plot
// for every pixel; x/y/plot are delayed one cycle to line up with ROM data.
module draw_sequencer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SPRITE_W = 40,
  parameter int SPRITE_H = 40,
  parameter int ADDR_W   = 15
) (
  input  logic            clk,
  input  logic            stateReset,
  draw_sequencer_if.slave bus
);

  localparam logic [7:0] SCR_COL_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] SCR_ROW_LAST = 7'(SCREEN_H - 1);
  localparam logic [7:0] SPR_COL_LAST = 8'(SPRITE_W - 1);
  localparam logic [6:0] SPR_ROW_LAST = 7'(SPRITE_H - 1);
  localparam logic [7:0] VIEW_W       = 8'(SCREEN_W);
  localparam logic [7:0] VIEW_H       = 8'(SCREEN_H);

  typedef enum logic [2:0] {IDLE, LOAD, DRAW, FLUSH, DONE} state_t;

  state_t            state_q;
  logic              job_sprite_q;
  logic              last_sprite_q;
  logic [7:0]        org_x_q;
  logic [6:0]        org_y_q;
  logic [7:0]        col_q;
  logic [6:0]        row_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [4:0]        mem_sel_q;
  logic              screen_ack_q;
  logic              sprite_ack_q;
  logic              plot_q;
  logic              done_q;
  logic              busy_q;
  logic [7:0]        x_q;
  logic [6:0]        y_q;

  logic              grant_screen;
  logic              grant_sprite;
  logic [7:0]        col_last;
  logic [6:0]        row_last;
  logic              last_pix;
  logic [7:0]        pix_x_d;
  logic [7:0]        pix_y_d;
  logic              in_view_d;

  // On a tie the requester that did not win last time is served.
  assign grant_sprite = bus.spriteReq && (!bus.screenReq || !last_sprite_q);
  assign grant_screen = bus.screenReq && (!bus.spriteReq || last_sprite_q);

  assign col_last = job_sprite_q ? SPR_COL_LAST : SCR_COL_LAST;
  assign row_last = job_sprite_q ? SPR_ROW_LAST : SCR_ROW_LAST;
  assign last_pix = (col_q == col_last) && (row_q == row_last);

  // Origin + offset never exceeds 8 bits for legal origins, so no carry is lost.
  assign pix_x_d   = job_sprite_q ? (org_x_q + col_q) : col_q;
  assign pix_y_d   = job_sprite_q ? ({1'b0, org_y_q} + {1'b0, row_q}) : {1'b0, row_q};
  assign in_view_d = (pix_x_d < VIEW_W) && (pix_y_d < VIEW_H);

  always_ff @(posedge clk or posedge stateReset) begin
    if (stateReset) begin
      state_q       <= IDLE;
      job_sprite_q  <= 1'b0;
      last_sprite_q <= 1'b1;
      org_x_q       <= '0;
      org_y_q       <= '0;
      col_q         <= '0;
      row_q         <= '0;
      rom_addr_q    <= '0;
      mem_sel_q     <= '0;
      screen_ack_q  <= 1'b0;
      sprite_ack_q  <= 1'b0;
      plot_q        <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
    end else begin
      screen_ack_q <= 1'b0;
      sprite_ack_q <= 1'b0;
      done_q       <= 1'b0;
      plot_q       <= (state_q == DRAW) && in_view_d;
      if (state_q == DRAW) begin
        x_q <= pix_x_d;
        y_q <= pix_y_d[6:0];
      end

      case (state_q)
        IDLE: begin
          if (grant_screen || grant_sprite) begin
            state_q       <= LOAD;
            busy_q        <= 1'b1;
            screen_ack_q  <= grant_screen;
            sprite_ack_q  <= grant_sprite;
            job_sprite_q  <= grant_sprite;
            last_sprite_q <= grant_sprite;
            mem_sel_q     <= grant_sprite ? bus.spriteSel : bus.screenSel;
            if (grant_sprite) begin
              org_x_q <= bus.spriteX;
              org_y_q <= bus.spriteY;
            end
          end
        end
        LOAD: begin
          state_q    <= DRAW;
          rom_addr_q <= '0;
          col_q      <= '0;
          row_q      <= '0;
        end
        DRAW: begin
          if (last_pix) begin
            state_q <= FLUSH;
          end else begin
            rom_addr_q <= rom_addr_q + ADDR_W'(1);
            if (col_q == col_last) begin
              col_q <= '0;
              row_q <= row_q + 7'd1;
            end else begin
              col_q <= col_q + 8'd1;
            end
          end
        end
        FLUSH: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.screenAck = screen_ack_q;
  assign bus.spriteAck = sprite_ack_q;
  assign bus.memorySel = mem_sel_q;
  assign bus.romAddr   = rom_addr_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.plot      = plot_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
